// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   N_REQ, IDX_W : requester count and grant index width
//   state_t      : arbiter FSM states (IDLE, BUSY)
//   SEG_LUT      : active-low {a,b,c,d,e,f,g} codes for digits 0..7
//   SEG_OFF      : blank display code
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int SEG_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  // Entry i holds the code for digit i (entry 0 is the rightmost literal).
  localparam logic [N_REQ-1:0][SEG_W-1:0] SEG_LUT = {
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/rr_pick8.sv
// Rotating first-set-bit picker: scans req from ptr upward modulo 8, optionally masking one index.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is used.
//
// Ports:
//   req      : request vector
//   mask_idx : index to ignore when mask_en is high (the current holder)
//   mask_en  : enables the mask
//   ptr      : first index to examine
//   found    : at least one unmasked request is set
//   win_idx  : first set index at or after ptr (wrapping); equals ptr when not found
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    cand = req;
    if (mask_en) begin
      cand[mask_idx] = 1'b0;
    end
    found    = 1'b0;
    win_idx  = ptr;
    scan_idx = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      // 3-bit addition wraps naturally, giving the modulo-8 scan order.
      scan_idx = ptr + IDX_W'(i);
      if (!found && cand[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Registered 8-requester round-robin arbiter with one-hot grant, index and 7-segment index display.
// Latency: one cycle from request to grant; a release hands over on the next edge with no idle cycle.
// Backpressure: a holder keeps the grant while its request stays high; en=0 blocks new grants only.
//
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   en        : arbitration enable
//   req[7:0]  : level-sensitive requests
//   gnt[7:0]  : one-hot grant (registered)
//   gnt_idx   : binary index of the holder (registered)
//   gnt_valid : a grant is active
//   seg[6:0]  : active-low {a..g} code of gnt_idx, blank when no grant
//
// Build option RR_ARB_HOLD_TIMEOUT_EN: a holder that has kept the grant for MAX_HOLD
// cycles is pre-empted when another requester is waiting and en=1.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16  // 1..255, only meaningful with the hold timeout built in
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [SEG_W-1:0] seg
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [SEG_W-1:0] seg_q, seg_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             holder_released;
  logic             rearb;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       hold_expired;
`endif

  // One picker serves both states: in IDLE nobody holds, so the mask is off;
  // in BUSY the holder is masked so a forced hand-over never re-picks it.
  rr_pick8 u_pick (
    .req     (req),
    .mask_idx(gnt_idx_q),
    .mask_en (state_q == BUSY),
    .ptr     (ptr_q),
    .found   (pick_found),
    .win_idx (pick_idx)
  );

  assign holder_released = !req[gnt_idx_q];

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  // Pre-emption only when someone else can actually take over.
  assign hold_expired = (hold_cnt_q == HOLD_LAST) && pick_found && en;
  assign rearb        = holder_released || hold_expired;
`else
  assign rearb        = holder_released;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    seg_d       = seg_q;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d     = BUSY;
          ptr_d       = pick_idx + IDX_W'(1);
          gnt_d       = N_REQ'(1) << pick_idx;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          seg_d       = SEG_LUT[pick_idx];
`ifdef RR_ARB_HOLD_TIMEOUT_EN
          hold_cnt_d  = 8'd0;
`endif
        end
      end

      BUSY: begin
        if (rearb) begin
          if (en && pick_found) begin
            // Direct hand-over: stay in BUSY, no bubble.
            ptr_d       = pick_idx + IDX_W'(1);
            gnt_d       = N_REQ'(1) << pick_idx;
            gnt_idx_d   = pick_idx;
            gnt_valid_d = 1'b1;
            seg_d       = SEG_LUT[pick_idx];
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt_d  = 8'd0;
`endif
          end else begin
            // Released with nobody eligible (or en low): drop back to IDLE.
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            seg_d       = SEG_OFF;
          end
        end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        else if (hold_cnt_q != HOLD_LAST) begin
          // Stops at the limit so a late-arriving requester pre-empts at once.
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      seg_q       <= SEG_OFF;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      seg_q       <= seg_d;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign seg       = seg_q;

endmodule
